// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and defaults for the branch predictor port arbiter
package bp_pkg;

    // Default predictor index width (pc bits used to address the local predictor)
    localparam int BP_PC_W = 7;

    // One queued resolution update; the FIFO stores it flattened as {pc, outcome}
    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               outcome;
    } bp_upd_t;

    // Port arbitration modes
    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } bp_state_t;

endpackage

// File: rtl/bp_update_fifo.sv
// rtl/bp_update_fifo.sv - in-order update queue with simultaneous push and pop
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered count, so a pop never frees a slot for a same-cycle push
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/bp_port_arbiter.sv
// rtl/bp_port_arbiter.sv - shares the predictor index port between fetch lookups and queued updates
module bp_port_arbiter
    import bp_pkg::*;
#(
    parameter int PC_W         = BP_PC_W,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_req,
    input  logic [PC_W-1:0]        fetch_pc,
    output logic                   fetch_grant,
    output logic                   fetch_prediction,
    input  logic                   resolve_valid,
    input  logic [PC_W-1:0]        resolve_pc,
    input  logic                   resolve_outcome,
    output logic                   resolve_ready,
    output logic [PC_W-1:0]        pred_pc_bits,
    output logic                   pred_update_en,
    output logic                   pred_outcome,
    input  logic                   pred_prediction,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   draining
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    bp_state_t     state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [PC_W:0] push_entry;
    logic [PC_W:0] head_entry;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          force_drain;
    logic          last_pop;

    assign push_entry       = {resolve_pc, resolve_outcome};
    assign resolve_ready    = reset || !fifo_full;
    assign push             = resolve_valid && resolve_ready && !reset;
    assign queue_count      = count;
    assign draining         = (state_q == ST_DRAIN);
    assign fetch_prediction = pred_prediction;
    assign force_drain      = (state_q == ST_NORMAL) && (starve_cnt_q == SW'(STARVE_LIMIT));
    // The head leaving now empties the queue unless a new entry lands on the same edge
    assign last_pop         = (count == CW'(1)) && !push;

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + 1)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_data_o (head_entry),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Port owner selection, FSM next state and starvation counter next value
    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        fetch_grant    = 1'b0;
        pred_update_en = 1'b0;
        pred_outcome   = 1'b0;
        pred_pc_bits   = fetch_pc;
        pop            = 1'b0;

        case (state_q)
            ST_NORMAL: begin
                if (fetch_req && !force_drain) begin
                    fetch_grant = 1'b1;
                end else if (!fifo_empty) begin
                    pred_pc_bits   = head_entry[PC_W:1];
                    pred_outcome   = head_entry[0];
                    pred_update_en = 1'b1;
                    pop            = 1'b1;
                end

                if (fifo_empty || pred_update_en) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
                    starve_cnt_d = starve_cnt_q + SW'(1);
                end

                // A forced update that empties the queue has nothing left to drain
                if (force_drain && !last_pop) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                starve_cnt_d = '0;
                if (!fifo_empty) begin
                    pred_pc_bits   = head_entry[PC_W:1];
                    pred_outcome   = head_entry[0];
                    pred_update_en = 1'b1;
                    pop            = 1'b1;
                end
                if (fifo_empty || last_pop) begin
                    state_d = ST_NORMAL;
                end
            end

            default: begin
                state_d = ST_NORMAL;
            end
        endcase

        // Reset holds the port quiet so a queued update cannot reach the predictor
        if (reset) begin
            fetch_grant    = 1'b0;
            pred_update_en = 1'b0;
            pred_outcome   = 1'b0;
            pred_pc_bits   = '0;
            pop            = 1'b0;
        end
    end

    // FSM state and starvation counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_port_arbiter.sv
// tb/tb_bp_port_arbiter.sv - directed self-checking bench for bp_port_arbiter
module tb_bp_port_arbiter;

    localparam int PC_W = 7;
    localparam int DEPTH = 4;
    localparam int STARVE_LIMIT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetch_req;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_grant;
    logic            fetch_prediction;
    logic            resolve_valid;
    logic [PC_W-1:0] resolve_pc;
    logic            resolve_outcome;
    logic            resolve_ready;
    logic [PC_W-1:0] pred_pc_bits;
    logic            pred_update_en;
    logic            pred_outcome;
    logic            pred_prediction;
    logic [2:0]      queue_count;
    logic            draining;

    int total = 0;
    int bad = 0;

    // Local predictor stand-in: 2-bit saturating counters, all starting strongly not-taken
    logic [1:0] ctr [128] = '{default: 2'b00};

    assign pred_prediction = ctr[pred_pc_bits][1];

    always @(posedge clk) begin
        if (pred_update_en) begin
            if (pred_outcome && ctr[pred_pc_bits] != 2'b11)
                ctr[pred_pc_bits] <= ctr[pred_pc_bits] + 2'b01;
            else if (!pred_outcome && ctr[pred_pc_bits] != 2'b00)
                ctr[pred_pc_bits] <= ctr[pred_pc_bits] - 2'b01;
        end
    end

    always #5 clk = ~clk;

    bp_port_arbiter #(
        .PC_W         (PC_W),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_req        (fetch_req),
        .fetch_pc         (fetch_pc),
        .fetch_grant      (fetch_grant),
        .fetch_prediction (fetch_prediction),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_outcome  (resolve_outcome),
        .resolve_ready    (resolve_ready),
        .pred_pc_bits     (pred_pc_bits),
        .pred_update_en   (pred_update_en),
        .pred_outcome     (pred_outcome),
        .pred_prediction  (pred_prediction),
        .queue_count      (queue_count),
        .draining         (draining)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_req = 1'b1; fetch_pc = 7'h05;
        resolve_valid = 1'b0; resolve_pc = '0; resolve_outcome = 1'b0;
        step(); step();
        total++; if (fetch_grant !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0b exp=0", fetch_grant); end
        total++; if (pred_update_en !== 1'b0) begin bad++; $display("FAIL rst_upd got=%0b exp=0", pred_update_en); end
        total++; if (pred_outcome !== 1'b0) begin bad++; $display("FAIL rst_outcome got=%0b exp=0", pred_outcome); end
        total++; if (pred_pc_bits !== 7'h00) begin bad++; $display("FAIL rst_pc got=%0h exp=0", pred_pc_bits); end
        total++; if (resolve_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", resolve_ready); end
        total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", queue_count); end
        total++; if (draining !== 1'b0) begin bad++; $display("FAIL rst_drain got=%0b exp=0", draining); end
        reset = 1'b0;
        #1;
        total++; if (fetch_grant !== 1'b1) begin bad++; $display("FAIL post_rst_grant got=%0b exp=1", fetch_grant); end
        total++; if (pred_pc_bits !== 7'h05) begin bad++; $display("FAIL post_rst_pc got=%0h exp=05", pred_pc_bits); end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_idle_update();
        fetch_req = 1'b0; resolve_valid = 1'b1; resolve_pc = 7'h15; resolve_outcome = 1'b1;
        #1;
        total++; if (pred_update_en !== 1'b0) begin bad++; $display("FAIL idle_no_bypass got=%0b exp=0", pred_update_en); end
        step();
        resolve_valid = 1'b0;
        #1;
        total++; if (pred_update_en !== 1'b1) begin bad++; $display("FAIL idle_upd got=%0b exp=1", pred_update_en); end
        total++; if (pred_pc_bits !== 7'h15) begin bad++; $display("FAIL idle_pc got=%0h exp=15", pred_pc_bits); end
        total++; if (pred_outcome !== 1'b1) begin bad++; $display("FAIL idle_outcome got=%0b exp=1", pred_outcome); end
        total++; if (queue_count !== 3'd1) begin bad++; $display("FAIL idle_count1 got=%0d exp=1", queue_count); end
        step();
        total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL idle_count0 got=%0d exp=0", queue_count); end
        total++; if (pred_update_en !== 1'b0) begin bad++; $display("FAIL idle_quiet got=%0b exp=0", pred_update_en); end
    endtask

    task automatic test_fetch_priority();
        fetch_req = 1'b1; fetch_pc = 7'h11;
        resolve_valid = 1'b1; resolve_pc = 7'h0A; resolve_outcome = 1'b0;
        step();
        resolve_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (fetch_grant !== 1'b1) begin bad++; $display("FAIL prio_grant[%0d] got=%0b exp=1", i, fetch_grant); end
            total++; if (pred_update_en !== 1'b0) begin bad++; $display("FAIL prio_upd[%0d] got=%0b exp=0", i, pred_update_en); end
            total++; if (pred_pc_bits !== 7'h11) begin bad++; $display("FAIL prio_pc[%0d] got=%0h exp=11", i, pred_pc_bits); end
            total++; if (queue_count !== 3'd1) begin bad++; $display("FAIL prio_count[%0d] got=%0d exp=1", i, queue_count); end
            step();
        end
        fetch_req = 1'b0;
        #1;
        total++; if (pred_update_en !== 1'b1) begin bad++; $display("FAIL prio_release_upd got=%0b exp=1", pred_update_en); end
        total++; if (pred_pc_bits !== 7'h0A) begin bad++; $display("FAIL prio_release_pc got=%0h exp=0a", pred_pc_bits); end
        step();
        total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL prio_end_count got=%0d exp=0", queue_count); end
    endtask

    // Queues three entries while fetch is busy, then runs up to the forced update
    task automatic starve_setup(input logic [PC_W-1:0] p0, input logic [PC_W-1:0] p1,
                                input logic [PC_W-1:0] p2);
        fetch_req = 1'b1; fetch_pc = 7'h01;
        resolve_valid = 1'b1; resolve_pc = p0; resolve_outcome = 1'b1;
        step();
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            resolve_valid = (i < 2);
            resolve_pc = (i == 0) ? p1 : p2;
            resolve_outcome = (i == 0) ? 1'b0 : 1'b1;
            #1;
            total++; if (fetch_grant !== 1'b1) begin bad++; $display("FAIL starve_grant[%0d] got=%0b exp=1", i, fetch_grant); end
            total++; if (pred_update_en !== 1'b0) begin bad++; $display("FAIL starve_upd[%0d] got=%0b exp=0", i, pred_update_en); end
            step();
        end
        resolve_valid = 1'b0;
        #1;
    endtask

    task automatic test_starvation();
        starve_setup(7'h21, 7'h22, 7'h23);
        total++; if (fetch_grant !== 1'b0) begin bad++; $display("FAIL force_grant got=%0b exp=0", fetch_grant); end
        total++; if (pred_update_en !== 1'b1) begin bad++; $display("FAIL force_upd got=%0b exp=1", pred_update_en); end
        total++; if (pred_pc_bits !== 7'h21) begin bad++; $display("FAIL force_pc got=%0h exp=21", pred_pc_bits); end
        total++; if (draining !== 1'b0) begin bad++; $display("FAIL force_drain got=%0b exp=0", draining); end
        step();
        total++; if (draining !== 1'b1) begin bad++; $display("FAIL drain1_flag got=%0b exp=1", draining); end
        total++; if (fetch_grant !== 1'b0) begin bad++; $display("FAIL drain1_grant got=%0b exp=0", fetch_grant); end
        total++; if (pred_pc_bits !== 7'h22 || pred_outcome !== 1'b0 || pred_update_en !== 1'b1)
            begin bad++; $display("FAIL drain1_upd got=%0h/%0b/%0b exp=22/0/1", pred_pc_bits, pred_outcome, pred_update_en); end
        step();
        total++; if (draining !== 1'b1) begin bad++; $display("FAIL drain2_flag got=%0b exp=1", draining); end
        total++; if (pred_pc_bits !== 7'h23 || pred_outcome !== 1'b1 || pred_update_en !== 1'b1)
            begin bad++; $display("FAIL drain2_upd got=%0h/%0b/%0b exp=23/1/1", pred_pc_bits, pred_outcome, pred_update_en); end
        step();
        total++; if (draining !== 1'b0) begin bad++; $display("FAIL post_drain_flag got=%0b exp=0", draining); end
        total++; if (fetch_grant !== 1'b1) begin bad++; $display("FAIL post_drain_grant got=%0b exp=1", fetch_grant); end
        total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL post_drain_count got=%0d exp=0", queue_count); end
        fetch_req = 1'b0;
    endtask

    task automatic test_full();
        logic [PC_W-1:0] pcs [4];
        pcs = '{7'h30, 7'h31, 7'h32, 7'h33};
        fetch_req = 1'b1; fetch_pc = 7'h02;
        for (int i = 0; i < 4; i++) begin
            resolve_valid = 1'b1; resolve_pc = pcs[i]; resolve_outcome = i[0];
            #1;
            total++; if (resolve_ready !== 1'b1) begin bad++; $display("FAIL full_ready[%0d] got=%0b exp=1", i, resolve_ready); end
            step();
        end
        fetch_req = 1'b0; resolve_pc = 7'h3F; resolve_outcome = 1'b1;
        #1;
        total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", queue_count); end
        total++; if (resolve_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", resolve_ready); end
        total++; if (pred_pc_bits !== 7'h30) begin bad++; $display("FAIL full_pop_pc got=%0h exp=30", pred_pc_bits); end
        step();
        resolve_valid = 1'b0;
        total++; if (queue_count !== 3'd3) begin bad++; $display("FAIL full_after_count got=%0d exp=3", queue_count); end
        for (int i = 1; i < 4; i++) begin
            #1;
            total++; if (pred_update_en !== 1'b1 || pred_pc_bits !== pcs[i])
                begin bad++; $display("FAIL full_order[%0d] got=%0h/%0b exp=%0h/1", i, pred_pc_bits, pred_update_en, pcs[i]); end
            step();
        end
        total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL full_end_count got=%0d exp=0", queue_count); end
    endtask

    task automatic test_order();
        logic exp_out [3];
        logic exp_pred [3];
        exp_out = '{1'b1, 1'b1, 1'b0};
        exp_pred = '{1'b0, 1'b1, 1'b0};
        fetch_req = 1'b1; fetch_pc = 7'h40;
        for (int i = 0; i < 3; i++) begin
            resolve_valid = 1'b1; resolve_pc = 7'h03; resolve_outcome = exp_out[i];
            step();
        end
        resolve_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fetch_req = 1'b0;
            #1;
            total++; if (pred_update_en !== 1'b1 || pred_pc_bits !== 7'h03 || pred_outcome !== exp_out[k])
                begin bad++; $display("FAIL order_wr[%0d] got=%0h/%0b/%0b exp=03/%0b/1", k, pred_pc_bits, pred_outcome, pred_update_en, exp_out[k]); end
            step();
            fetch_req = 1'b1; fetch_pc = 7'h03;
            #1;
            total++; if (fetch_grant !== 1'b1 || fetch_prediction !== exp_pred[k])
                begin bad++; $display("FAIL order_lookup[%0d] got=%0b/%0b exp=1/%0b", k, fetch_grant, fetch_prediction, exp_pred[k]); end
            step();
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_reset_drain();
        starve_setup(7'h51, 7'h52, 7'h53);
        step();
        total++; if (draining !== 1'b1 || queue_count !== 3'd2)
            begin bad++; $display("FAIL rd_setup got=%0b/%0d exp=1/2", draining, queue_count); end
        reset = 1'b1; resolve_valid = 1'b1; resolve_pc = 7'h54;
        #1;
        total++; if (pred_update_en !== 1'b0) begin bad++; $display("FAIL rd_upd_in_reset got=%0b exp=0", pred_update_en); end
        step();
        reset = 1'b0; resolve_valid = 1'b0; fetch_req = 1'b0;
        #1;
        total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL rd_count got=%0d exp=0", queue_count); end
        total++; if (draining !== 1'b0) begin bad++; $display("FAIL rd_drain got=%0b exp=0", draining); end
        total++; if (pred_update_en !== 1'b0) begin bad++; $display("FAIL rd_upd got=%0b exp=0", pred_update_en); end
        total++; if (ctr[7'h52] !== 2'b00) begin bad++; $display("FAIL rd_no_write got=%0d exp=0", ctr[7'h52]); end
        step();
    endtask

    initial begin
        test_reset();
        test_idle_update();
        test_fetch_priority();
        test_starvation();
        test_full();
        test_order();
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
